// File: rtl/l2_cache_control.sv
// ---------------------------------------------------------------------------
// l2_cache_control
//
// Control FSM for the 2-way set-associative L2 cache. It drives the read,
// load and index controls of the tag/valid/dirty/LRU/data arrays. It serves
// L1 requests on one side and line-sized physical-memory bursts on the other.
// The three cases it handles are hit, clean-miss fill and dirty-miss
// writeback followed by a fill.
//
// Optional feature macro: L2_PERF_CNT_EN
//   defined   -> hit_count / miss_count / wb_count are live 32-bit wrapping
//                counters, cleared by rst
//   undefined -> the counter ports exist but are tied to zero
//
// Parameters
//   s_offset      line offset bits (32-byte line)
//   s_index       set index bits, must match the arrays
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   mem_read/mem_write    L1 request, held with mem_address until mem_resp
//   mem_address           L1 request address
//   mem_resp              single-cycle request completion
//   hit, hit_way          tag-match result from the arrays (addr_q index)
//   lru_way               victim way chosen by the LRU array
//   victim_dirty          dirty bit of the victim way
//   victim_tag            tag of the victim way
//   array_read            read enable to all arrays
//   rindex, windex        array read / write index
//   load_tag/valid/dirty  per-way array load enables
//   load_data             per-way data load enable
//   dirty_in              value written into the dirty array
//   data_sel              0 = merge L1 write data, 1 = take the pmem line
//   load_lru, lru_in      LRU update
//   pmem_read/pmem_write  line transaction request, held until pmem_resp
//   pmem_address          line-aligned physical address
//   pmem_resp             pmem transaction complete
//   hit_count, miss_count, wb_count   performance counters
// ---------------------------------------------------------------------------
module l2_cache_control #(
    parameter int s_offset = 5,
    parameter int s_index  = 4,
    localparam int s_tag   = 32 - s_offset - s_index
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_address,
    output logic               mem_resp,

    input  logic               hit,
    input  logic               hit_way,
    input  logic               lru_way,
    input  logic               victim_dirty,
    input  logic [s_tag-1:0]   victim_tag,

    output logic               array_read,
    output logic [s_index-1:0] rindex,
    output logic [s_index-1:0] windex,
    output logic [1:0]         load_tag,
    output logic [1:0]         load_valid,
    output logic [1:0]         load_dirty,
    output logic               dirty_in,
    output logic [1:0]         load_data,
    output logic               data_sel,
    output logic               load_lru,
    output logic               lru_in,

    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    input  logic               pmem_resp,

    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count,
    output logic [31:0]        wb_count
);

    typedef enum logic [1:0] {
        IDLE,
        TAG_CHECK,
        WRITEBACK,
        FILL
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic        victim_q;
    logic        refill_q;

    logic        req_seen;
    logic        miss_seen;

    // The byte-offset bits of addr_q are kept only so the register holds
    // the full request address. No output reads them.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr_q[s_offset-1:0];

    assign req_seen  = (state == IDLE) && (mem_read || mem_write);
    assign miss_seen = (state == TAG_CHECK) && !hit;

    // State and request bookkeeping. The address is captured once when the
    // request is accepted, so the arrays keep seeing a stable index through
    // the whole miss sequence. The victim way is frozen at the first miss
    // check. Later LRU updates cannot move the fill target that way.
    // refill_q marks the post-fill re-check, which keeps that cycle out of
    // the hit statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            victim_q <= 1'b0;
            refill_q <= 1'b0;
        end else begin
            state <= state_next;
            if (req_seen) begin
                addr_q   <= mem_address;
                refill_q <= 1'b0;
            end
            if (miss_seen) begin
                victim_q <= lru_way;
            end
            if ((state == FILL) && pmem_resp) begin
                refill_q <= 1'b1;
            end
        end
    end

    // Next-state and output decode. Every output defaults to an idle
    // value. In IDLE the read index follows the incoming address, so the
    // arrays are already presenting the right set in the TAG_CHECK cycle.
    // The fill writes tag, valid, clean dirty bit and line into the victim
    // way together. The arrays bypass same-cycle writes, so the TAG_CHECK
    // that follows always hits and completes the original request.
    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        array_read   = 1'b0;
        rindex       = addr_q[s_offset +: s_index];
        windex       = addr_q[s_offset +: s_index];
        load_tag     = 2'b00;
        load_valid   = 2'b00;
        load_dirty   = 2'b00;
        dirty_in     = 1'b0;
        load_data    = 2'b00;
        data_sel     = 1'b0;
        load_lru     = 1'b0;
        lru_in       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;

        case (state)
            IDLE: begin
                rindex = mem_address[s_offset +: s_index];
                if (mem_read || mem_write) begin
                    state_next = TAG_CHECK;
                end
            end

            TAG_CHECK: begin
                array_read = 1'b1;
                if (hit) begin
                    mem_resp   = 1'b1;
                    load_lru   = 1'b1;
                    lru_in     = ~hit_way;
                    // A combined read+write request is served as a write.
                    if (mem_write) begin
                        load_data[hit_way]  = 1'b1;
                        load_dirty[hit_way] = 1'b1;
                        dirty_in            = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    state_next = victim_dirty ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {victim_tag, addr_q[s_offset +: s_index],
                                {s_offset{1'b0}}};
                if (pmem_resp) begin
                    state_next = FILL;
                end
            end

            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {addr_q[31:s_offset], {s_offset{1'b0}}};
                if (pmem_resp) begin
                    load_data[victim_q]  = 1'b1;
                    load_tag[victim_q]   = 1'b1;
                    load_valid[victim_q] = 1'b1;
                    load_dirty[victim_q] = 1'b1;
                    dirty_in             = 1'b0;
                    data_sel             = 1'b1;
                    state_next           = TAG_CHECK;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef L2_PERF_CNT_EN
    // Performance counters. A hit counts only on the first look-up of a
    // request, because the re-check after a fill always hits. A writeback
    // counts when the line has actually been accepted by pmem.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if ((state == TAG_CHECK) && hit && !refill_q) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_seen) begin
                miss_count <= miss_count + 32'd1;
            end
            if ((state == WRITEBACK) && pmem_resp) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule
